// File: rtl/hazard_control.sv
// hazard_control
//   Stall/flush controller for a 5-stage RV32I pipeline. Handles the hazards
//   that forwarding cannot cover:
//   - a load-use dependency inserts a one-cycle bubble;
//   - a taken branch or jump resolved in EX squashes IF/ID and ID/EX;
//   - a data-memory access that is not ready freezes the pipeline.
//   It also keeps saturating stall/flush statistics and a memory-wait
//   watchdog for the debug CSR block.
//
// Ports
//   clk, reset            pipeline clock, asynchronous active-high reset
//   id_rs1/id_rs2         source registers of the instruction in ID
//   id_use_rs1/id_use_rs2 ID instruction actually reads rs1/rs2
//   ex_rd, ex_memread     destination and load flag of the EX instruction
//   ex_branch_taken       EX redirects the PC
//   dmem_req, dmem_ready  MEM-stage access handshake
//   pc_write .. memwb_flush  pipeline-register enables and flushes (combinational)
//   stall_cnt, flush_cnt  saturating statistics counters
//   mem_timeout           sticky watchdog flag
module hazard_control #(
  parameter int CNT_WIDTH = 32,
  parameter int MAX_WAIT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_memread,
  input  logic                 ex_branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_write,
  output logic                 idex_flush,
  output logic                 exmem_write,
  output logic                 memwb_flush,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

  state_t               state, state_n;
  logic [15:0]          wait_cnt, wait_n;
  logic                 timeout_n;
  logic [CNT_WIDTH-1:0] stall_n, flush_n;
  logic                 memwait, loaduse, branch_flush;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}}))
      return v + CNT_WIDTH'(1);
    return v;
  endfunction

  assign memwait = dmem_req & ~dmem_ready;
  assign loaduse = ex_memread & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) |
                    (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_write  = 1'b1;
    memwb_flush  = 1'b0;
    branch_flush = 1'b0;
    state_n      = state;
    wait_n       = wait_cnt;
    timeout_n    = mem_timeout;

    // Hazard outputs are forced to the no-hazard values while reset is held.
    if (!reset) begin
      if (memwait) begin
        // Freeze: EX is held, so branch/load-use are re-evaluated after release.
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        branch_flush = 1'b1;
      end else if (loaduse) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end

    case (state)
      ST_RUN: begin
        if (memwait) begin
          state_n = ST_WAIT;
          wait_n  = 16'd1;
        end
      end
      default: begin
        if (!memwait) begin
          state_n = ST_RUN;
          wait_n  = 16'd0;
        end else if (wait_cnt != MAX_W) begin
          wait_n = wait_cnt + 16'd1;
        end
      end
    endcase

    if (wait_n == MAX_W)
      timeout_n = 1'b1;

    stall_n = sat_inc(stall_cnt, ~pc_write);
    flush_n = sat_inc(flush_cnt, branch_flush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      mem_timeout <= timeout_n;
      stall_cnt   <= stall_n;
      flush_cnt   <= flush_n;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a behavioural model (priority table for the control outputs,
//   plain integer counters and a consecutive-wait run length for the state).
module tb_hazard_control;

  localparam int CW   = 3;
  localparam int MAXW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic          ex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic          dmem_req = 1'b0, dmem_ready = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic          exmem_write, memwb_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  hazard_control #(.CNT_WIDTH(CW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .memwb_flush(memwb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare #1 later, advance the model at posedge.
  // ctrl order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush}
  task automatic apply(input string tag, input bit rst,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd,
                       input bit mr, input bit bt, input bit req, input bit rdy);
    bit       mw, lu;
    bit [6:0] ec;
    @(negedge clk);
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_memread = mr; ex_branch_taken = bt; dmem_req = req; dmem_ready = rdy;
    mw = req && !rdy;
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst)     ec = 7'b1101010;
    else if (mw) ec = 7'b0000001;
    else if (bt) ec = 7'b1111110;
    else if (lu) ec = 7'b0001110;
    else         ec = 7'b1101010;
    if (rst) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
    end
    #1;
    chk({tag, ".ctrl"}, 32'({pc_write, ifid_write, ifid_flush, idex_write,
                             idex_flush, exmem_write, memwb_flush}), 32'(ec));
    chk({tag, ".stall"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush"}, 32'(flush_cnt), 32'(m_flush));
    chk({tag, ".tmo"}, 32'(mem_timeout), 32'(m_to));
    @(posedge clk);
    if (!rst) begin
      if (!ec[6] && m_stall < CMAX) m_stall++;
      if (!mw && bt && m_flush < CMAX) m_flush++;
      m_run = mw ? m_run + 1 : 0;
      if (m_run >= MAXW) m_to = 1'b1;
    end
  endtask

  task automatic idle(input string tag);
    apply(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    apply("rst", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    do_reset();
    idle("idle0");

    // Load-use on rs2: one bubble, then defaults.
    apply("lu", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("lu_after", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // x0 destination and unused operand never stall.
    apply("x0", 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("unused", 1'b0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // Branch overrides load-use.
    apply("br_lu", 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("br_after");

    // Memory wait with a taken branch held in EX.
    do_reset();
    for (int i = 0; i < 3; i++)
      apply("mw_br", 1'b0, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    apply("mw_rel", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("mw_done");

    // Watchdog trips on the 4th consecutive wait edge and stays sticky.
    do_reset();
    for (int i = 0; i < 6; i++)
      apply("wd", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("wd_rdy", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("wd_sticky");
    apply("wd_again", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Reset asserted mid-wait, checked before any clock edge.
    apply("wd_rst", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("post_rst");

    // Stall counter saturation.
    for (int i = 0; i < 9; i++)
      apply("sat", 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("sat_hold");

    // Flush counter saturation.
    do_reset();
    for (int i = 0; i < 9; i++)
      apply("fsat", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("fsat_hold");

    // Randomized traffic with narrow register fields to provoke matches.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      apply("rnd", ($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), ($urandom_range(0, 3) == 0),
            1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Stall/flush side of the 5-stage RV32I pipeline hazard logic; bypass muxes cover all other data hazards.
- Takes over where bypass cannot help:
  - load-use hazards get a one-cycle bubble;
  - taken branches/jumps resolved in EX flush the younger stages;
  - a data-memory access that is not ready freezes the pipeline.
- Keeps saturating stall/flush counters and a memory-wait watchdog, read by the debug CSR block.
- Sits beside the ID/EX control path and drives the pipeline-register write-enables and flushes.

Parameters:
- CNT_WIDTH, 32, width of the stall_cnt and flush_cnt statistic counters.
- MAX_WAIT, 64, consecutive memory-wait cycles that trip the watchdog (legal range 1..65535).

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- id_rs1  input  5  rs1 of instruction in ID
- id_rs2  input  5  rs2 of instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  rd of instruction in EX
- ex_memread  input  1  EX instruction is a load
- ex_branch_taken  input  1  EX redirects PC (taken branch, jal, jalr)
- dmem_req  input  1  MEM stage has an active load/store
- dmem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC register enable
- ifid_write  output  1  IF/ID enable
- ifid_flush  output  1  IF/ID to NOP
- idex_write  output  1  ID/EX enable
- idex_flush  output  1  ID/EX to bubble
- exmem_write  output  1  EX/MEM enable
- memwb_flush  output  1  MEM/WB to bubble
- stall_cnt  output  CNT_WIDTH  cycles with pc_write=0
- flush_cnt  output  CNT_WIDTH  branch flush events
- mem_timeout  output  1  sticky watchdog flag

Behaviour:
- Control outputs are combinational from the current inputs and state; zero added latency.
- Counters, watchdog and state are registered on the clk rising edge.
- Reset, asynchronous, high:
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - While reset is high, control outputs are the RUN no-hazard values.
- Default, no hazard: all *_write=1, all flushes=0.
- Decode terms:
  - memwait = dmem_req & ~dmem_ready.
  - loaduse = ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority, highest first:
  1. memwait (freeze):
     - pc_write, ifid_write, idex_write, exmem_write = 0.
     - memwb_flush=1; ifid_flush=0, idex_flush=0.
     - ex_branch_taken and loaduse are ignored this cycle. They are re-evaluated when the freeze lifts, because EX is held.
  2. ex_branch_taken (flush):
     - pc_write=1, ifid_flush=1, idex_flush=1, remaining writes=1.
     - Overrides loaduse because the ID instruction is squashed.
  3. loaduse (bubble):
     - pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1.
     - Lasts exactly one cycle; next cycle the load is in MEM and the bypass path resolves the operand.
- FSM states:
  - RUN: if memwait, go to WAIT and set wait_cnt=1.
  - WAIT:
    - if dmem_ready or ~dmem_req, go to RUN and clear wait_cnt;
    - else wait_cnt increments, saturating at MAX_WAIT.
    - When wait_cnt reaches MAX_WAIT, mem_timeout sets on that edge and stays 1 until reset.
  - The freeze follows memwait only, not state; the pipeline stays frozen after a timeout while memwait holds.
- Counters:
  - stall_cnt += 1 on each edge where pc_write=0.
  - flush_cnt += 1 on each edge where the branch-flush case is active.
  - Both saturate at all-ones and never wrap.
- Reset mid-freeze or mid-bubble: everything returns to reset values immediately, with no residual stall.

Test Plan:
- Load-use, single cycle:
  - Stimulus: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1.
  - Response: one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1.
  - Next cycle with ex_memread=0: defaults.
- x0 and unused operand:
  - ex_rd=0 with id_rs1=0 -> no stall.
  - ex_rd=7, id_rs1=7, id_use_rs1=0 -> no stall.
- Branch over load-use:
  - Stimulus: ex_branch_taken=1 with loaduse true.
  - Response: pc_write=1, ifid_flush=1, idex_flush=1; flush_cnt 0->1; stall_cnt unchanged.
- Memory wait:
  - Stimulus: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1, with ex_branch_taken=1 throughout.
  - Response: 3 frozen cycles with memwb_flush=1 and no flush; stall_cnt=3.
  - Fourth cycle: branch flush, flush_cnt=1, state RUN.
- Watchdog:
  - Stimulus: MAX_WAIT=4, memwait held 6 cycles.
  - Response: mem_timeout rises on the 4th edge and stays 1 after ready; pipeline frozen all 6 cycles; stall_cnt=6.
  - Assert reset mid-wait: all outputs return to reset values asynchronously.
- Saturation: CNT_WIDTH=3, 9 consecutive load-use cycles -> stall_cnt holds at 7.
